// File: rtl/ps2_kbd_rx_fifo_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the receive FSM states, the STATUS bit positions and the register selects.
package flounder_ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam int STAT_NE   = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_PERR = 3;
  localparam int STAT_FERR = 4;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

endpackage

// File: rtl/ps2_kbd_rx_fifo_if.sv
// CPU-side register bus of the PS/2 receiver (Z180 I/O space behind the CPLD decode).
// Access: CS high with R low drives D_OUT (D_OE high); the R rising edge while CS is
// high completes the access, popping DATA or clearing the sticky STATUS flags.
interface ps2_kbd_rx_fifo_if;
  logic       CS;
  logic       R;
  logic       A0;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic       IRQ;

  modport master (output CS, R, A0, input D_OUT, D_OE, IRQ);
  modport slave  (input CS, R, A0, output D_OUT, D_OE, IRQ);
endinterface

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered empty/full flags.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr, wptr_n, rptr_n;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wptr_n  = wptr + {{AW{1'b0}}, do_push};
  assign rptr_n  = rptr + {{AW{1'b0}}, do_pop};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      empty <= (wptr_n == rptr_n);
      full  <= (wptr_n[AW-1:0] == rptr_n[AW-1:0]) && (wptr_n[AW] != rptr_n[AW]);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: synchronised, glitch-filtered clock, framed receive FSM,
// scan-code FIFO and DATA/STATUS register pair with a not-empty interrupt.
module ps2_kbd_rx_fifo
  import flounder_ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 36864
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 KB_CLK,
  input  logic                 KB_DATA,
  ps2_kbd_rx_fifo_if.slave     bus,
  output rx_state_e            dbg_state
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic [FW-1:0]          filt_cnt;
  logic                   clk_f, sample, data_s;
  rx_state_e              state;
  logic [7:0]             shreg;
  logic [2:0]             bit_cnt;
  logic                   par_bit;
  logic [TW-1:0]          to_cnt;
  logic                   perr_q, ferr_q, ovr_q, r_q;
  logic                   rd_rise, pop, status_clr, par_ok, push, ovr_evt, timeout;
  logic [7:0]             fifo_rdata, status;
  logic                   fifo_empty, fifo_full;

  // Idle-high reset values keep the line from looking like a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      clk_sync <= '1;
      dat_sync <= '1;
      filt_cnt <= '0;
      clk_f    <= 1'b1;
      sample   <= 1'b0;
      data_s   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], KB_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], KB_DATA};
      sample   <= 1'b0;
      if (clk_sync[SYNC_STAGES-1] == clk_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        clk_f    <= clk_sync[SYNC_STAGES-1];
        sample   <= clk_f;
        if (clk_f) data_s <= dat_sync[SYNC_STAGES-1];
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign rd_rise    = bus.CS && bus.R && !r_q;
  assign pop        = rd_rise && (bus.A0 == REG_DATA);
  assign status_clr = rd_rise && (bus.A0 == REG_STATUS);
  assign par_ok     = ^{shreg, par_bit};
  assign push       = sample && (state == STOP) && data_s && par_ok;
  assign ovr_evt    = push && fifo_full && !(pop && !fifo_empty);
  assign timeout    = (state != IDLE) && !sample && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      r_q     <= 1'b1;
    end else begin
      r_q <= bus.R;
      if (state == IDLE || sample) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
      // Clear first so a sticky event in the same cycle wins.
      if (status_clr) begin
        ovr_q  <= 1'b0;
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (ovr_evt) ovr_q <= 1'b1;
      if (timeout) begin
        state  <= IDLE;
        ferr_q <= 1'b1;
      end else if (sample) begin
        case (state)
          IDLE: begin
            if (data_s) ferr_q <= 1'b1;
            else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg[bit_cnt] <= data_s;
            bit_cnt        <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_s) ferr_q <= 1'b1;
            if (!par_ok) perr_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  ps2_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (shreg),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    status            = '0;
    status[STAT_NE]   = !fifo_empty;
    status[STAT_FULL] = fifo_full;
    status[STAT_OVR]  = ovr_q;
    status[STAT_PERR] = perr_q;
    status[STAT_FERR] = ferr_q;
  end

  assign bus.D_OE = bus.CS && !bus.R;
  assign bus.IRQ  = !fifo_empty;
  assign dbg_state = state;

  always_comb begin
    bus.D_OUT = 8'h00;
    if (bus.D_OE) begin
      if (bus.A0 == REG_STATUS) bus.D_OUT = status;
      else if (!fifo_empty)     bus.D_OUT = fifo_rdata;
    end
  end

endmodule

// File: doc/ps2_kbd_rx_fifo.md
# ps2_kbd_rx_fifo

Parametrised PS/2 keyboard receiver with a scan-code FIFO, a status register and an interrupt output, mapped into Z180 I/O space behind the CPLD I/O decode. It replaces single-register scan-code latching with a glitch-filtered, edge-detected receiver that checks start, parity and stop bits. Scan codes are buffered so that the CPU can drain bursts such as break/extended sequences without loss.

## Interface
- `FIFO_DEPTH`, 8: scan-code entries. Power of two, 2..64.
- `SYNC_STAGES`, 2: flops on `KB_CLK` and `KB_DATA` before use. Range 2..4.
- `FILTER_LEN`, 4: consecutive equal synchronised samples required before the filtered `KB_CLK` changes.
- `TIMEOUT_CYCLES`, 36864: maximum CLK cycles between falling edges inside a frame. This is 2 ms at 18.432 MHz.
- `CLK` in 1: system clock.
- `RST` in 1: asynchronous, active-low reset.
- `KB_CLK` in 1: PS/2 clock. Asynchronous, open-drain, idle high.
- `KB_DATA` in 1: PS/2 data. Asynchronous.
- `CS` in 1: active-high block select from the external I/O decode.
- `R` in 1: active-low read strobe.
- `A0` in 1: register select. 0 selects DATA, 1 selects STATUS.
- `D_OUT` out 8: read data.
- `D_OE` out 1: high while `CS` is high and `R` is low. The top level drives the bus from `D_OUT` only while this is high.
- `IRQ` out 1: active-high interrupt request.

## Operation
- **Input conditioning.** Both PS/2 inputs pass through `SYNC_STAGES` flops.
  - Filtered `KB_CLK` resets to 1.
  - A falling edge of filtered `KB_CLK` produces a one-cycle `sample` pulse.
  - `sample` latches the synchronised `KB_DATA`.
- **Receive FSM states:**
  - IDLE: on `sample`, data 0 goes to DATA with bit count 0. Data 1 stays in IDLE and sets FERR.
  - DATA: on each `sample`, shift data into bit[count], LSB first. After count 7, go to PARITY.
  - PARITY: on `sample`, store the parity bit and go to STOP.
  - STOP: on `sample`, evaluate the frame and go to IDLE.
- **Frame evaluation in STOP.**
  - Good frame: stop bit is 1 and the XOR of the 8 data bits plus the parity bit is 1 (odd parity). The byte is pushed.
  - Parity failure sets PERR. Stop bit 0 sets FERR. In both cases the byte is discarded.
- **Timeout.** In any state other than IDLE, a cycle counter reloads on each `sample`. If it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, sets FERR and discards the partial byte.
- **FIFO push.** If the FIFO is full, the new byte is dropped, OVR is set and the FIFO contents are unchanged.
- **DATA read (`A0`=0).**
  - `D_OUT` shows the FIFO head, or 0x00 when the FIFO is empty.
  - One pop occurs on the cycle in which `R` rises with `CS` high. No pop occurs when the FIFO is empty.
- **STATUS read (`A0`=1).**
  - Bit 0 NE (not empty). Bit 1 FULL. Bit 2 OVR. Bit 3 PERR. Bit 4 FERR. Bits 7:5 are 0.
  - OVR, PERR and FERR are sticky. They clear on the `R` rising edge of a STATUS read.
  - If a sticky event occurs in that same cycle, the flag stays set.
- **IRQ** = NE, registered.

## Timing
- **Reset values:** `D_OUT`=0x00, `D_OE`=0, `IRQ`=0, FSM in IDLE, FIFO empty, all flags 0.
- **`KB_CLK` pin to `sample` latency:** `SYNC_STAGES` + `FILTER_LEN` + 1 cycles.
- **Push latency:** the stop-bit `sample` cycle pushes the byte. NE, FULL and `IRQ` update on the next edge.
- **`D_OUT` and `D_OE`** are combinational from `CS`, `R`, `A0` and registered state.
- **Simultaneous push and pop:**
  - Both succeed and the count is unchanged.
  - When the FIFO is full, the pop is processed first, so the push is accepted and OVR is not set.
- **Pointer wrap:** pointers are log2(`FIFO_DEPTH`) bits plus one wrap bit. Full is indicated by equal indices with differing wrap bits.
- **Mid-frame reset:** asserting `RST` mid-frame aborts the frame immediately. The next frame is received correctly only if it starts after `RST` deasserts.

## Structure
- **Package `flounder_ps2_pkg`** holds:
  - The FSM state enum (IDLE, DATA, PARITY, STOP).
  - Status bit index constants (NE=0, FULL=1, OVR=2, PERR=3, FERR=4).
  - Register select constants (REG_DATA=0, REG_STATUS=1).
- **Sub-module `ps2_sync_fifo`:** a parametrised synchronous FIFO with ports push, pop, wdata, rdata, empty and full.
- **Top level** holds the input conditioning, the receive FSM and the register interface.

## Test plan
- **Good frame:** send 0x1C with parity 0 -> STATUS=0x01, `IRQ`=1. A DATA read returns 0x1C. A following STATUS read returns 0x00 and `IRQ` falls.
- **Parity error:** send 0x1C with parity 1 -> nothing is pushed and STATUS=0x08. A second STATUS read returns 0x00.
- **Overflow (`FIFO_DEPTH`=8):** send 9 frames 0x01..0x09 -> STATUS=0x07. Eight DATA reads return 0x01..0x08, then a DATA read returns 0x00.
- **Timeout:** send a start bit plus 3 data bits, then idle for `TIMEOUT_CYCLES`+10 -> STATUS=0x10. A following clean frame 0xF0 is received intact.
- **Glitch and concurrency:**
  - A 2-cycle low glitch on `KB_CLK` with `FILTER_LEN`=4 -> no `sample` pulse.
  - With the FIFO full, a DATA-read `R` rise in the same cycle as a stop-bit push -> count stays 8 and OVR stays 0.
- **Mid-frame reset:** assert `RST` after 5 data bits -> all outputs at reset values. The next full frame 0x5A reads back as 0x5A.
